pipe_stage_skid: RTL and testbench

- Parametrised pipeline-stage register for the 5-stage datapath; the next generation of the fixed-field per-stage latches (fetch-to-decode, decode-to-execute, execute-to-memory, memory-to-writeback).
- Carries a DATA_W-bit datapath payload and a CTRL_W-bit control payload, plus a valid bit.
- Uses a ready/valid handshake with a one-entry skid buffer, so a downstream stall never loses data and the upstream ready signal is registered.
- A flush input squashes in-flight entries by turning them into bubbles (control zeroed); this is used on branch mispredict.

---
 rtl/pipe_stage_skid_pkg.sv | 27 ++
 rtl/pipe_reg_en.sv | 21 ++
 rtl/pipe_stage_skid.sv | 130 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions: occupancy codes, default widths, control-field
// layout and the skid-stage state encoding used by every pipeline register.
package pipe_stage_skid_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CTRL_W = 8;

  // Control payload layout, identical in every stage so fields line up.
  localparam int REGWRT_BIT = 0;
  localparam int MEMWRT_BIT = 1;
  localparam int READEN_BIT = 2;
  localparam int WBSEL_LSB  = 3;
  localparam int WRTREG_LSB = 4;

  // Bit 0 is main_valid and bit 1 is skid_valid, so the valid bits are the
  // state flops themselves and in_ready is a pure flop output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

endpackage

// File: rtl/pipe_reg_en.sv
// Generic payload register: async reset to zero, synchronous clear that wins
// over the load enable (used to squash control on flush).
module pipe_reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register update: clear has priority over load, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a one-entry skid buffer so that upstream ready
// is registered, plus a flush that turns every held entry into a bubble.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int GATE_CTRL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occ
);

  state_t state, state_nxt;

  logic main_valid, skid_valid;
  logic acc, pop;
  logic main_load, skid_load, main_from_skid;

  logic [DATA_W-1:0] main_data, skid_data, main_data_d;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;

  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign acc        = in_valid & in_ready;
  assign pop        = main_valid & out_ready;
  assign occ        = {1'b0, main_valid} + {1'b0, skid_valid};

  // When the skid drains, the older skid entry moves into main.
  assign main_data_d = main_from_skid ? skid_data : in_data;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;

  // State register; the valid bits live in the state encoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  // Next-state and register-load decisions; flush overrides every transfer.
  always_comb begin
    state_nxt      = state;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_load = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            main_load = 1'b1;
          end else if (acc) begin
            skid_load = 1'b1;
            state_nxt = ST_FULL;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_nxt      = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  pipe_reg_en #(.WIDTH(DATA_W)) u_main_data (
    .clk(clk), .rst(rst), .en(main_load), .clr(1'b0),
    .d(main_data_d), .q(main_data)
  );

  pipe_reg_en #(.WIDTH(CTRL_W)) u_main_ctrl (
    .clk(clk), .rst(rst), .en(main_load), .clr(flush),
    .d(main_ctrl_d), .q(main_ctrl)
  );

  pipe_reg_en #(.WIDTH(DATA_W)) u_skid_data (
    .clk(clk), .rst(rst), .en(skid_load), .clr(1'b0),
    .d(in_data), .q(skid_data)
  );

  pipe_reg_en #(.WIDTH(CTRL_W)) u_skid_ctrl (
    .clk(clk), .rst(rst), .en(skid_load), .clr(flush),
    .d(in_ctrl), .q(skid_ctrl)
  );

  assign out_data = main_data;

  // An idle stage can hold stale control; gating keeps it from looking live.
  generate
    if (GATE_CTRL != 0) begin : g_gate
      assign out_ctrl = main_ctrl & {CTRL_W{main_valid}};
    end else begin : g_nogate
      assign out_ctrl = main_ctrl;
    end
  endgenerate

  a_no_orphan_skid : assert property (@(posedge clk) disable iff (rst)
    !(skid_valid && !main_valid));

  a_occ_legal : assert property (@(posedge clk) disable iff (rst)
    occ != 2'd3);

  a_stall_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=>
      (out_valid && $stable(out_data) && $stable(out_ctrl)));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table, directed corner sequences and a
// queue scoreboard that shadows the stage on every cycle.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready, in_ready_ng;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid, out_valid_ng;
  logic        out_ready;
  logic [63:0] out_data, out_data_ng;
  logic [7:0]  out_ctrl, out_ctrl_ng;
  logic [1:0]  occ, occ_ng;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } entry_t;

  entry_t sb_q[$];

  typedef struct {
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic [1:0]  exp_occ;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .GATE_CTRL(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .occ(occ)
  );

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .GATE_CTRL(0)) dut_ng (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_ng),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_ng), .out_ready(out_ready),
    .out_data(out_data_ng), .out_ctrl(out_ctrl_ng), .occ(occ_ng)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] d, input logic [7:0] c,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: between edges, compare against the model queue, then advance
  // the model by what the coming edge will do.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      checkOutput("sb_occ", {62'd0, occ}, 64'(sb_q.size()));
      checkOutput("sb_in_ready", {63'd0, in_ready}, {63'd0, sb_q.size() < 2});
      checkOutput("sb_out_valid", {63'd0, out_valid}, {63'd0, sb_q.size() != 0});
      if (sb_q.size() != 0) begin
        checkOutput("sb_out_data", out_data, sb_q[0].data);
        checkOutput("sb_out_ctrl", {56'd0, out_ctrl}, {56'd0, sb_q[0].ctrl});
      end else begin
        checkOutput("sb_gated_ctrl", {56'd0, out_ctrl}, 64'd0);
      end
      begin
        automatic bit model_acc = in_valid && (sb_q.size() < 2);
        if (sb_q.size() != 0 && out_ready) void'(sb_q.pop_front());
        if (flush) sb_q.delete();
        else if (model_acc) sb_q.push_back('{data: in_data, ctrl: in_ctrl});
      end
    end
  end

  initial begin
    // Streaming then stall/skid: expected values are those after the edge.
    vecs[0] = '{1'b1, 64'h1, 1'b1, 1'b1, 64'h1, 2'd1, 1'b1};
    vecs[1] = '{1'b1, 64'h2, 1'b1, 1'b1, 64'h2, 2'd1, 1'b1};
    vecs[2] = '{1'b1, 64'h3, 1'b1, 1'b1, 64'h3, 2'd1, 1'b1};
    vecs[3] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h3, 2'd0, 1'b1};
    vecs[4] = '{1'b1, 64'hA, 1'b0, 1'b1, 64'hA, 2'd1, 1'b1};
    vecs[5] = '{1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 2'd2, 1'b0};
    vecs[6] = '{1'b1, 64'hD, 1'b0, 1'b1, 64'hA, 2'd2, 1'b0};
    vecs[7] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'hB, 2'd1, 1'b1};
    vecs[8] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'hB, 2'd0, 1'b1};

    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 8'h0, 1'b0, 1'b0);
    #3;
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_data", out_data, 64'd0);
    checkOutput("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    checkOutput("rst_occ", {62'd0, occ}, 64'd0);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].in_data, 8'h10 + 8'(i), vecs[i].out_ready, 1'b0);
      step();
      checkOutput($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_occ", i), {62'd0, occ}, {62'd0, vecs[i].exp_occ});
      checkOutput($sformatf("vec%0d_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].exp_ready});
    end

    // Flush while FULL with live control, with a simultaneous offer of 0xC.
    applyStimulus(1'b1, 64'h11, 8'hFF, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 64'h22, 8'hFF, 1'b0, 1'b0);
    step();
    checkOutput("flush_pre_occ", {62'd0, occ}, 64'd2);
    applyStimulus(1'b1, 64'hC, 8'hFF, 1'b0, 1'b1);
    step();
    checkOutput("flush_occ", {62'd0, occ}, 64'd0);
    checkOutput("flush_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("flush_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    checkOutput("flush_ctrl_ungated", {56'd0, out_ctrl_ng}, 64'd0);
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd1);

    // Flush in ONE with an acceptable offer: the offer must be dropped.
    applyStimulus(1'b1, 64'h33, 8'h01, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 64'hC, 8'h02, 1'b0, 1'b1);
    step();
    checkOutput("flush1_occ", {62'd0, occ}, 64'd0);
    applyStimulus(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("flush_no_emit", {63'd0, out_valid}, 64'd0);
    end

    // Stale control in an idle stage: gated instance shows 0, ungated does not.
    applyStimulus(1'b1, 64'h77, 8'h5A, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
    step();
    checkOutput("gate_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("gate_on_ctrl", {56'd0, out_ctrl}, 64'd0);
    checkOutput("gate_off_ctrl", {56'd0, out_ctrl_ng}, 64'h5A);

    // Asynchronous reset mid-cycle while FULL.
    applyStimulus(1'b1, 64'h44, 8'h03, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 64'h55, 8'h04, 1'b0, 1'b0);
    step();
    checkOutput("rst2_pre_occ", {62'd0, occ}, 64'd2);
    applyStimulus(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst2_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst2_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    checkOutput("rst2_occ", {62'd0, occ}, 64'd0);
    checkOutput("rst2_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst2_no_emit", {63'd0, out_valid}, 64'd0);
    end

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom),
                    1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      step();
    end

    applyStimulus(1'b0, 64'h0, 8'h0, 1'b1, 1'b0);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
